// File: rtl/ex_mdu_ctrl.sv
// Iterative multiply/divide controller for the EX stage.
// Unsigned shift-add multiply and restoring divide, one iteration per cycle,
// with pipeline stall, abort (flush) and a one-cycle done pulse.
module ex_mdu_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_Op1,
   input  logic [WIDTH-1:0] i_Op2,
   input  logic             i_abort,
   output logic             o_stall,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   localparam int unsigned CNT_W  = 6;
   localparam int unsigned PROD_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [PROD_W-1:0]  prod_q, prod_d;
   logic [WIDTH-1:0]   div_q, div_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic [WIDTH:0]     add_sum;
   logic [PROD_W-1:0]  prod_step;
   logic [WIDTH:0]     rem_sh;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_step;
   logic [WIDTH-1:0]   quo_step;
   logic               last_iter;

   // One iteration of each algorithm, computed from the current registers
   always_comb begin
      add_sum   = {1'b0, prod_q[PROD_W-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_step = {add_sum, prod_q[WIDTH-1:1]};
      rem_sh    = {rem_q, quo_q[WIDTH-1]};
      rem_ge    = (rem_sh >= {1'b0, div_q});
      rem_step  = rem_ge ? WIDTH'(rem_sh - {1'b0, div_q}) : rem_sh[WIDTH-1:0];
      quo_step  = {quo_q[WIDTH-2:0], rem_ge};
      last_iter = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Next-state, datapath update and stall/busy/done outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      div_d    = div_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      result_d = result_q;
      o_stall  = 1'b0;
      o_busy   = 1'b0;
      o_done   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_abort) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               op_d    = i_op;
               mcand_d = i_Op1;
               prod_d  = {WIDTH'(0), i_Op2};
               div_d   = i_Op2;
               rem_d   = '0;
               quo_d   = i_Op1;
               o_stall = 1'b1;
            end
         end
         ST_RUN: begin
            o_busy = 1'b1;
            if (i_abort) begin
               // stale operands are never read again; the next accept reloads them
               state_d = ST_IDLE;
            end else begin
               o_stall = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               if (op_q[1]) begin
                  rem_d = rem_step;
                  quo_d = quo_step;
               end else begin
                  prod_d = prod_step;
               end
               if (last_iter) begin
                  state_d = ST_DONE;
                  case (op_q)
                     2'b00:   result_d = prod_step[WIDTH-1:0];
                     2'b01:   result_d = prod_step[PROD_W-1:WIDTH];
                     2'b10:   result_d = quo_step;
                     default: result_d = rem_step;
                  endcase
               end
            end
         end
         ST_DONE: begin
            o_busy  = 1'b1;
            o_done  = !i_abort;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (reset) begin
         o_stall = 1'b0;
         o_busy  = 1'b0;
         o_done  = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         div_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         div_q    <= div_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         result_q <= result_d;
      end
   end

   assign o_result = result_q;

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Self-checking bench for ex_mdu_ctrl: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_ex_mdu_ctrl;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_start;
   logic [1:0]    i_op;
   logic [W-1:0]  i_Op1;
   logic [W-1:0]  i_Op2;
   logic          i_abort;
   logic          o_stall;
   logic          o_busy;
   logic          o_done;
   logic [W-1:0]  o_result;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] last_result;

   ex_mdu_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_start  (i_start),
      .i_op     (i_op),
      .i_Op1    (i_Op1),
      .i_Op2    (i_Op2),
      .i_abort  (i_abort),
      .o_stall  (o_stall),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_result (o_result)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it on mismatch
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference result from plain arithmetic
   function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (op)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issue one op at cycle T and check stall/done timing and the result
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold_start);
      logic [W-1:0] exp;
      exp = ref_result(op, a, b);
      @(negedge clk);
      i_start = 1'b1; i_op = op; i_Op1 = a; i_Op2 = b;
      #1;
      check_eq("accept_stall", 64'(o_stall), 64'd1);
      check_eq("accept_busy",  64'(o_busy),  64'd0);
      check_eq("accept_done",  64'(o_done),  64'd0);
      for (int k = 1; k <= int'(W); k++) begin
         @(negedge clk);
         if (!hold_start) begin
            i_start = 1'b0;
            i_op    = 2'($urandom);
            i_Op1   = $urandom;
            i_Op2   = $urandom;
         end
         #1;
         check_eq("run_stall", 64'(o_stall), 64'd1);
         check_eq("run_done",  64'(o_done),  64'd0);
         check_eq("run_busy",  64'(o_busy),  64'd1);
      end
      @(negedge clk);
      #1;
      check_eq("done_pulse", 64'(o_done),   64'd1);
      check_eq("done_stall", 64'(o_stall),  64'd0);
      check_eq("done_busy",  64'(o_busy),   64'd1);
      check_eq("result",     64'(o_result), 64'(exp));
      last_result = exp;
      if (hold_start) begin
         i_start = 1'b0;
         @(negedge clk);
         #1;
         check_eq("hold_no_accept_busy", 64'(o_busy),   64'd0);
         check_eq("hold_no_accept_done", 64'(o_done),   64'd0);
         check_eq("hold_result_kept",    64'(o_result), 64'(exp));
      end
   endtask

   initial begin
      reset = 1'b1; i_start = 1'b1; i_abort = 1'b1; i_op = 2'd0; i_Op1 = '0; i_Op2 = '0;
      @(negedge clk);
      #1;
      check_eq("rst_stall", 64'(o_stall), 64'd0);
      check_eq("rst_busy",  64'(o_busy),  64'd0);
      check_eq("rst_done",  64'(o_done),  64'd0);
      @(negedge clk);
      reset = 1'b0; i_start = 1'b0; i_abort = 1'b0;
      #1;
      check_eq("rst_result", 64'(o_result), 64'd0);
      check_eq("rst_idle",   64'(o_busy),   64'd0);
      last_result = '0;

      // directed arithmetic cases, issued back to back
      run_op(2'd0, 32'd7, 32'd6, 1'b0);
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd2, 32'd100, 32'd7, 1'b0);
      run_op(2'd3, 32'd100, 32'd7, 1'b0);
      run_op(2'd2, 32'd5, 32'd0, 1'b0);
      run_op(2'd3, 32'd5, 32'd0, 1'b0);

      // i_start held through DONE must not start a second op
      run_op(2'd0, 32'd12345, 32'd678, 1'b1);

      // abort with start in IDLE is not accepted
      @(negedge clk);
      i_start = 1'b1; i_abort = 1'b1; i_op = 2'd2; i_Op1 = 32'd9; i_Op2 = 32'd3;
      #1;
      check_eq("idle_abort_stall", 64'(o_stall), 64'd0);
      @(negedge clk);
      i_start = 1'b0; i_abort = 1'b0;
      #1;
      check_eq("idle_abort_busy", 64'(o_busy), 64'd0);

      // abort at T+10 during DIVU
      @(negedge clk);
      i_start = 1'b1; i_op = 2'd2; i_Op1 = 32'd1000; i_Op2 = 32'd3;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         i_start = 1'b0;
      end
      i_abort = 1'b1;
      #1;
      check_eq("abort_stall", 64'(o_stall), 64'd0);
      check_eq("abort_done",  64'(o_done),  64'd0);
      @(negedge clk);
      i_abort = 1'b0;
      #1;
      check_eq("abort_busy",   64'(o_busy),   64'd0);
      check_eq("abort_result", 64'(o_result), 64'(last_result));
      for (int k = 0; k < int'(W) + 4; k++) begin
         @(negedge clk);
         #1;
         check_eq("abort_no_done", 64'(o_done), 64'd0);
      end

      // reset at T+5 mid-MUL
      @(negedge clk);
      i_start = 1'b1; i_op = 2'd0; i_Op1 = 32'd11; i_Op2 = 32'd13;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         i_start = 1'b0;
      end
      reset = 1'b1;
      #1;
      check_eq("midrst_stall", 64'(o_stall), 64'd0);
      check_eq("midrst_busy",  64'(o_busy),  64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("midrst_idle",   64'(o_busy),   64'd0);
      check_eq("midrst_result", 64'(o_result), 64'd0);
      check_eq("midrst_done",   64'(o_done),   64'd0);
      last_result = '0;
      run_op(2'd0, 32'd3, 32'd3, 1'b0);

      // random ops, some with small or zero divisors
      for (int n = 0; n < 24; n++) begin
         logic [1:0]   op;
         logic [W-1:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 17));
            default: b = $urandom;
         endcase
         run_op(op, a, b, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
